regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the multi-issue CPU core.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_wr_sel.sv | 35 +++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its write-select helper.
package regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NR    = 2;
  localparam int DEF_NW    = 2;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/regfile_wr_sel.sv
// Per-register priority select across the write ports: the highest-numbered
// port targeting a register supplies its data; register 0 never sees a write.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NW    = DEF_NW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [NW-1:0]          we,
  input  logic [NW*AW-1:0]       waddr,
  input  logic [NW*WIDTH-1:0]    wdata,
  output logic [DEPTH-1:0]       hit,
  output logic [DEPTH*WIDTH-1:0] hdata,
  output logic [DEPTH-1:0]       clr
);

  always_comb begin
    hit   = '0;
    hdata = '0;
    // Ascending port order makes the last matching port the winner.
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NW; p++) begin
        if (we[p] && (waddr[p*AW +: AW] == AW'(a)) && (a != ZERO_REG)) begin
          hit[a]                  = 1'b1;
          hdata[a*WIDTH +: WIDTH] = wdata[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign clr = hit;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write->read bypass
// and a per-register busy scoreboard (issue reserves, writeback releases).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NR     = DEF_NR,
  parameter int NW     = DEF_NW,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NW-1:0]       we,
  input  logic [NW*AW-1:0]    waddr,
  input  logic [NW*WIDTH-1:0] wdata,
  input  logic [NR*AW-1:0]    raddr,
  output logic [NR*WIDTH-1:0] rdata,
  output logic [NR-1:0]       rbusy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [AW:0]         busy_cnt
);

  logic [DEPTH-1:0]       hit;
  logic [DEPTH-1:0]       clr;
  logic [DEPTH*WIDTH-1:0] hdata;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       busy_nxt;
  logic [DEPTH-1:0]       rsv_mask;
  logic [AW-1:0]          ra;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int k = 0; k < DEPTH; k++) n = n + {{AW{1'b0}}, v[k]};
    return n;
  endfunction

  regfile_wr_sel #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NW    (NW),
    .AW    (AW)
  ) u_wr_sel (
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .hit   (hit),
    .hdata (hdata),
    .clr   (clr)
  );

  // Register 0 is reset and never loaded, so it stays constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      for (int a = 1; a < DEPTH; a++) begin
        if (hit[a]) mem[a] <= hdata[a*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rsv_mask = '0;
    if (rsv_en && (rsv_addr != AW'(ZERO_REG))) rsv_mask[rsv_addr] = 1'b1;
  end

  // Reserve is applied after the clear so a newer producer keeps the register busy.
  assign busy_nxt = (busy & ~clr) | rsv_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  // Outputs are forced to zero while reset is asserted, even if a bypass write is pending.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NR; i++) begin
      ra = raddr[i*AW +: AW];
      if (rst_n && (ra != AW'(ZERO_REG))) begin
        if ((BYPASS != 0) && hit[ra])
          rdata[i*WIDTH +: WIDTH] = hdata[int'(ra)*WIDTH +: WIDTH];
        else
          rdata[i*WIDTH +: WIDTH] = mem[ra];
        rbusy[i] = busy[ra] && !((BYPASS != 0) && clr[ra] && !rsv_mask[ra]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, corner-case sequences and
// randomized traffic against a behavioural model (BYPASS=1 and BYPASS=0 instances).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  we = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic [5:0]  busy_cnt, busy_cnt_nb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rsv;
    logic [4:0]  rsa;
    logic [31:0] er0;
    logic [31:0] er1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  vec_t tbl[$];

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NR(2), .NW(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NR(2), .NW(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_nb)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic rsv, input logic [4:0] rsa);
    we       = w;
    waddr    = {wa1, wa0};
    wdata    = {wd1, wd0};
    raddr    = {ra1, ra0};
    rsv_en   = rsv;
    rsv_addr = rsa;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m_mem[r] = '0;
    m_busy = '0;
  endtask

  // Reference model: a register array and a busy bit set, updated from the spec rules.
  function automatic bit written(input logic [4:0] a);
    for (int p = 0; p < 2; p++)
      if (we[p] && waddr[p*5 +: 5] == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'd0;
    v = m_mem[a];
    if (byp)
      for (int p = 0; p < 2; p++)
        if (we[p] && waddr[p*5 +: 5] == a) v = wdata[p*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_rb(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && written(a) && !(rsv_en && rsv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    for (int p = 0; p < 2; p++)
      if (we[p] && waddr[p*5 +: 5] != 0) m_mem[waddr[p*5 +: 5]] = wdata[p*32 +: 32];
    for (int p = 0; p < 2; p++)
      if (we[p] && waddr[p*5 +: 5] != 0) m_busy[waddr[p*5 +: 5]] = 1'b0;
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
  endtask

  initial begin
    tbl.push_back('{2'b01, 5'd1, 32'h12345678, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 5'd0, 32'h12345678, 32'h0, 2'b00, 6'd0});
    tbl.push_back('{2'b10, 5'd0, 32'h0, 5'd2, 32'h87654321, 5'd2, 5'd1, 1'b0, 5'd0, 32'h87654321, 32'h12345678, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd1, 1'b0, 5'd0, 32'h87654321, 32'h12345678, 2'b00, 6'd0});
    tbl.push_back('{2'b11, 5'd5, 32'hAAAA0000, 5'd5, 32'h5555FFFF, 5'd5, 5'd5, 1'b0, 5'd0, 32'h5555FFFF, 32'h5555FFFF, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h5555FFFF, 32'h0, 2'b00, 6'd0});
    tbl.push_back('{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1, 5'd0, 32'h0, 32'h5555FFFF, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3, 32'h0, 32'h0, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b01, 6'd1});
    tbl.push_back('{2'b01, 5'd3, 32'h11112222, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3, 32'h11112222, 32'h0, 2'b01, 6'd1});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h11112222, 32'h11112222, 2'b11, 6'd1});
    tbl.push_back('{2'b01, 5'd3, 32'h33334444, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h33334444, 32'h33334444, 2'b00, 6'd1});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h33334444, 32'h0, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd3, 1'b1, 5'd4, 32'h0, 32'h33334444, 2'b00, 6'd0});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4, 32'h0, 32'h0, 2'b01, 6'd1});
    tbl.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0, 32'h0, 2'b11, 6'd1});

    // Reset state on every register through both read ports.
    do_reset();
    for (int r = 0; r < 32; r++) begin
      raddr = {5'(r), 5'(31 - r)};
      #1;
      check($sformatf("reset_rdata_r%0d", r), rdata, 64'd0);
      check($sformatf("reset_rbusy_r%0d", r), 64'(rbusy), 64'd0);
    end
    check("reset_busy_cnt", 64'(busy_cnt), 64'd0);
    check("reset_rdata_nb", rdata_nb, 64'd0);

    // Directed vector table on the bypassing instance.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
            tbl[i].ra0, tbl[i].ra1, tbl[i].rsv, tbl[i].rsa);
      @(negedge clk);
      check($sformatf("tbl%0d_rdata0", i), 64'(rdata[31:0]), 64'(tbl[i].er0));
      check($sformatf("tbl%0d_rdata1", i), 64'(rdata[63:32]), 64'(tbl[i].er1));
      check($sformatf("tbl%0d_rbusy", i), 64'(rbusy), 64'(tbl[i].eb));
      check($sformatf("tbl%0d_busy_cnt", i), 64'(busy_cnt), 64'(tbl[i].ec));
    end
    @(posedge clk);
    #1 idle();

    // Bypass versus no-bypass timing of a write to reg7.
    do_reset();
    @(posedge clk); #1;
    drive(2'b01, 5'd7, 32'h01020304, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    check("byp_first_rdata", 64'(rdata[31:0]), 64'h01020304);
    check("nobyp_first_rdata", 64'(rdata_nb[31:0]), 64'h0);
    @(posedge clk); #1;
    drive(2'b01, 5'd7, 32'hCAFEF00D, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    check("byp_same_cycle", 64'(rdata[31:0]), 64'hCAFEF00D);
    check("nobyp_same_cycle_old", 64'(rdata_nb[31:0]), 64'h01020304);
    @(posedge clk); #1;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    check("nobyp_next_cycle", 64'(rdata_nb[31:0]), 64'hCAFEF00D);
    check("byp_next_cycle", 64'(rdata[31:0]), 64'hCAFEF00D);

    // Asynchronous reset asserted mid-cycle with a reservation and a write in flight.
    @(posedge clk); #1;
    drive(2'b01, 5'd6, 32'h00000066, 5'd0, 32'd0, 5'd6, 5'd4, 1'b1, 5'd4);
    @(posedge clk); #1;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 5'd4, 1'b0, 5'd0);
    #1;
    check("prerst_busy_cnt", 64'(busy_cnt), 64'd1);
    check("prerst_rbusy", 64'(rbusy), 64'b10);
    check("prerst_rdata0", 64'(rdata[31:0]), 64'h66);
    we = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'd0, 32'h00000077};
    #1;
    check("prerst_bypass", 64'(rdata[31:0]), 64'h77);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_cnt", 64'(busy_cnt), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    check("midrst_rbusy", 64'(rbusy), 64'd0);
    check("midrst_rdata_nb", rdata_nb, 64'd0);
    @(posedge clk); #1;
    check("rst_hold_rdata", rdata, 64'd0);
    check("rst_hold_busy_cnt", 64'(busy_cnt_nb), 64'd0);
    idle();
    raddr = {5'd4, 5'd6};
    #2 rst_n = 1'b1;
    #1;
    check("postrst_rdata", rdata, 64'd0);

    // Randomized traffic against the model, both instances.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      model_update();
      #1;
      we       = 2'($urandom_range(0, 3));
      waddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) waddr[4:0] = 5'($urandom_range(0, 31));
      wdata    = {32'($urandom), 32'($urandom)};
      raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rnd%0d_rdata%0d", n, i), 64'(rdata[i*32 +: 32]), 64'(exp_rd(raddr[i*5 +: 5], 1'b1)));
        check($sformatf("rnd%0d_rdata_nb%0d", n, i), 64'(rdata_nb[i*32 +: 32]), 64'(exp_rd(raddr[i*5 +: 5], 1'b0)));
        check($sformatf("rnd%0d_rbusy%0d", n, i), 64'(rbusy[i]), 64'(exp_rb(raddr[i*5 +: 5], 1'b1)));
        check($sformatf("rnd%0d_rbusy_nb%0d", n, i), 64'(rbusy_nb[i]), 64'(exp_rb(raddr[i*5 +: 5], 1'b0)));
      end
      check($sformatf("rnd%0d_busy_cnt", n), 64'(busy_cnt), 64'($countones(m_busy)));
      check($sformatf("rnd%0d_busy_cnt_nb", n), 64'(busy_cnt_nb), 64'($countones(m_busy)));
    end
    @(posedge clk);
    #1 idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
